// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: widths, the NOP
// shown while the prefetch queue is empty, the fetch state encoding and the
// PC increment helper used wherever an address advances by one word.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Word increment with natural 32-bit wrap-around (FFFF_FFFC + 4 = 0).
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue holding {pc, instr} pairs between the memory response
// port and decode. Pointers and count are cleared by the async reset and by
// flush; the storage itself is never reset because the head is only
// consumed while the queue is non-empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [XLEN-1:0]         wr_pc,
  input  logic [XLEN-1:0]         wr_instr,
  output logic [XLEN-1:0]         head_pc,
  output logic [XLEN-1:0]         head_instr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      pc_mem[wr_ptr]    <= wr_pc;
      instr_mem[wr_ptr] <= wr_instr;
    end
  end

  // The fetch credit scheme must never let a response land in a full queue.
  push_into_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Stallable, redirectable instruction fetch stage. Issues word requests to
// instruction memory under a credit limit of DEPTH (in flight + queued),
// buffers responses in fetch_fifo and presents the head to decode over a
// valid/ready handshake. Redirects flush the queue and count stale
// in-flight responses so they are discarded on arrival.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to add the
// fetch_misaligned output and the HALT state entered on a redirect to a
// non-word-aligned target; otherwise the target's low two bits are ignored.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;
  logic [CW:0]     in_use;
  logic            credit_ok;
  logic            pop;
  logic            accept;
  logic            redirect_take;
  logic            bad_redirect;
  logic [XLEN-1:0] target_pc;
  logic            keep_rsp;

  // Redirects are ignored once halted; the queue is already empty and no
  // further fetching will happen until reset.
  assign redirect_take = redirect_valid && (state_q != HALT);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q;

  assign target_pc        = redirect_pc;
  assign bad_redirect     = redirect_take && (redirect_pc[1:0] != 2'b00);
  assign fetch_misaligned = misaligned_q;

  // Sticky misalignment flag, set together with the entry into HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               misaligned_q <= 1'b0;
    else if (bad_redirect) misaligned_q <= 1'b1;
  end
`else
  logic unused_redirect_lsbs;

  assign target_pc            = {redirect_pc[XLEN-1:2], 2'b00};
  assign bad_redirect         = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign pop       = instr_valid && instr_ready;
  assign accept    = imem_req_valid && imem_req_ready;
  assign in_use    = {1'b0, outstanding} + {1'b0, q_count} - (CW + 1)'(pop);
  assign credit_ok = in_use < (CW + 1)'(DEPTH);
  assign keep_rsp  = imem_rsp_valid && !redirect_take && (drop_cnt == '0)
                     && (state_q != HALT);

  // Fetch state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Next state: BOOT lasts one cycle, a misaligned redirect halts for good.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = bad_redirect ? HALT : RUN;
      RUN:     if (bad_redirect) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Request output: only in RUN, never in a redirect cycle, and only while
  // a queue slot is guaranteed for the eventual response.
  always_comb begin
    imem_req_valid = (state_q == RUN) && !redirect_valid && credit_ok;
  end

  assign imem_addr = fetch_pc;

  // PC counters, in-flight count and stale-response drop count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect_take) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (accept) fetch_pc <= pc_inc(fetch_pc);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (keep_rsp) rsp_pc <= pc_inc(rsp_pc);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (keep_rsp),
    .pop        (pop && !redirect_take),
    .flush      (redirect_take),
    .wr_pc      (rsp_pc),
    .wr_instr   (imem_rsp_data),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (q_count),
    .empty      (q_empty),
    .full       (q_full)
  );

  // While the queue is empty decode sees a NOP at the next expected PC.
  assign instr_valid    = !q_empty;
  assign instr          = q_empty ? NOP_INSTR : head_instr;
  assign instr_pc       = q_empty ? rsp_pc : head_pc;
  assign instr_pc_plus4 = pc_inc(instr_pc);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a latency-programmable memory,
// a queue-based behavioural model of the fetch stage, directed scenarios
// pinned with literal values and a randomized soak.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // behavioural model
  ent_t        mq[$];
  logic [31:0] m_fetch, m_rsp;
  int          m_out, m_drop;
  bit          m_run, m_halt;

  // memory
  logic [31:0] mp_addr[$];
  int          mp_due[$];

  // knobs
  int          lat_min = 1, lat_max = 1;
  int          p_reqr = 100, p_insr = 100, p_rsp = 100, p_redir = 0;
  bit          redir_now = 1'b0;
  logic [31:0] redir_target = '0;

  // logs
  logic [31:0] seen_pc[$], seen_p4[$], seen_ins[$], acc_addr[$];
  int          acc_count, first_acc_cyc, first_valid_cyc;

  // saved pre-edge view
  bit          s_acc, s_pop, s_rsp, s_redir;
  logic [31:0] s_data, s_rpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkLog(input string name, input logic [31:0] q[$], input int idx,
                        input logic [31:0] exp);
    if (q.size() > idx) chk(name, q[idx], exp);
    else begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: only %0d entries logged, expected entry %0d = %h",
               name, q.size(), idx, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < p_reqr);
    instr_ready    = ($urandom_range(99) < p_insr);
    if (redir_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_now      = 1'b0;
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_pc[1:0] = 2'b00;
`endif
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    if (mp_addr.size() > 0 && mp_due[0] <= cyc && $urandom_range(99) < p_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mp_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic checkOutput();
    bit pop, exp_req;
    pop     = (mq.size() > 0) && instr_ready;
    exp_req = m_run && !m_halt && !redirect_valid && ((m_out + mq.size() - (pop ? 1 : 0)) < DEPTH);
    chk("imem_req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_fetch);
    chk("instr_valid", instr_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("instr", instr, mq[0].ins);
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("instr_pc_plus4", instr_pc_plus4, mq[0].pc + 32'd4);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("fetch_misaligned", fetch_misaligned, m_halt);
`endif
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (instr_valid && instr_ready && !redirect_valid) begin
      seen_pc.push_back(instr_pc);
      seen_p4.push_back(instr_pc_plus4);
      seen_ins.push_back(instr);
    end
    if (imem_rsp_valid) begin
      void'(mp_addr.pop_front());
      void'(mp_due.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      acc_count++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      acc_addr.push_back(imem_addr);
      mp_addr.push_back(imem_addr);
      mp_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    s_acc   = exp_req && imem_req_ready;
    s_pop   = pop;
    s_rsp   = imem_rsp_valid;
    s_data  = imem_rsp_data;
    s_redir = redirect_valid;
    s_rpc   = redirect_pc;
  endtask

  task automatic updateModel();
    if (s_redir && !m_halt) begin
      mq.delete();
      m_drop = m_out - (s_rsp ? 1 : 0);
      m_out  = m_out - (s_rsp ? 1 : 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (s_rpc[1:0] != 2'b00) m_halt = 1'b1;
      else begin
        m_fetch = s_rpc;
        m_rsp   = s_rpc;
      end
`else
      m_fetch = s_rpc & ~32'h3;
      m_rsp   = s_rpc & ~32'h3;
`endif
    end else begin
      if (s_acc) begin
        m_fetch = m_fetch + 32'd4;
        m_out++;
      end
      if (s_pop) void'(mq.pop_front());
      if (s_rsp) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else if (!m_halt) begin
          mq.push_back('{pc: m_rsp, ins: s_data});
          m_rsp = m_rsp + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      #1 checkOutput();
      @(posedge clk);
      updateModel();
    end
  endtask

  task automatic clearLogs();
    seen_pc.delete();
    seen_p4.delete();
    seen_ins.delete();
    acc_addr.delete();
    acc_count = 0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    redir_now      = 1'b0;
    mq.delete();
    mp_addr.delete();
    mp_due.delete();
    m_out = 0; m_drop = 0; m_run = 1'b0; m_halt = 1'b0;
    m_fetch = RESET_PC; m_rsp = RESET_PC;
    clearLogs();
    first_acc_cyc = -1; first_valid_cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0000);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0000_0000);
    chk("rst_instr_pc_plus4", instr_pc_plus4, 32'h0000_0004);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fetch_misaligned", fetch_misaligned, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1 chk("boot_req_valid", imem_req_valid, 1'b0);
    @(posedge clk);
    m_run = 1'b1;
    cyc   = 1;
  endtask

  task automatic setKnobs(input int lmin, input int lmax, input int preq, input int pins,
                          input int prsp, input int prd);
    lat_min = lmin; lat_max = lmax; p_reqr = preq; p_insr = pins; p_rsp = prsp; p_redir = prd;
  endtask

  initial begin
    int guard;

    // Straight-line fetch with 1-cycle memory and decode always ready.
    setKnobs(1, 1, 100, 100, 100, 0);
    doReset();
    runCycles(8);
    chk("A_first_accept_cycle", first_acc_cyc, 1);
    chk("A_first_valid_cycle", first_valid_cyc, 3);
    chkLog("A_addr0", acc_addr, 0, 32'h0);
    chkLog("A_addr1", acc_addr, 1, 32'h4);
    chkLog("A_addr2", acc_addr, 2, 32'h8);
    chkLog("A_pc0", seen_pc, 0, 32'h0);
    chkLog("A_pc1", seen_pc, 1, 32'h4);
    chkLog("A_pc2", seen_pc, 2, 32'h8);
    chkLog("A_p4_0", seen_p4, 0, 32'h4);
    chkLog("A_p4_1", seen_p4, 1, 32'h8);
    chkLog("A_p4_2", seen_p4, 2, 32'hC);
    chkLog("A_ins0", seen_ins, 0, mem_word(32'h0));
    chk("A_pcs_per_cycle", seen_pc.size(), 6);

    // Decode stalled: credit caps requests at DEPTH, then release in order.
    setKnobs(1, 1, 100, 0, 100, 0);
    doReset();
    runCycles(10);
    chk("B_accepts_while_stalled", acc_count, 4);
    #1;
    chk("B_stalled_valid", instr_valid, 1'b1);
    chk("B_stalled_pc", instr_pc, 32'h0);
    p_insr = 100;
    clearLogs();
    runCycles(8);
    for (int i = 0; i < 5; i++) chkLog("B_release_pc", seen_pc, i, 32'(4 * i));

    // 3-cycle memory, redirect with two requests in flight.
    setKnobs(3, 3, 100, 100, 100, 0);
    doReset();
    guard = 0;
    while (m_out != 2 && guard < 10) begin
      runCycles(1);
      guard++;
    end
    chk("C_accepts_before_redirect", acc_count, 2);
    redir_now = 1'b1;
    redir_target = 32'h0000_0100;
    clearLogs();
    runCycles(12);
    chkLog("C_first_pc_after_redirect", seen_pc, 0, 32'h100);
    chkLog("C_first_ins_after_redirect", seen_ins, 0, mem_word(32'h100));
    chkLog("C_second_pc_after_redirect", seen_pc, 1, 32'h104);

    // Memory not ready: request holds, redirect moves it to the new target.
    setKnobs(1, 1, 0, 100, 100, 0);
    doReset();
    runCycles(2);
    #1;
    chk("D_waiting_valid", imem_req_valid, 1'b1);
    chk("D_waiting_addr", imem_addr, 32'h0);
    redir_now = 1'b1;
    redir_target = 32'h0000_0040;
    runCycles(3);
    p_reqr = 100;
    clearLogs();
    runCycles(4);
    chkLog("D_first_accept_after_redirect", acc_addr, 0, 32'h40);

    // Address wrap-around at the top of the 32-bit space.
    redir_now = 1'b1;
    redir_target = 32'hFFFF_FFF8;
    clearLogs();
    runCycles(8);
    chkLog("E_pc0", seen_pc, 0, 32'hFFFF_FFF8);
    chkLog("E_pc1", seen_pc, 1, 32'hFFFF_FFFC);
    chkLog("E_pc2", seen_pc, 2, 32'h0000_0000);
    chkLog("E_p4_of_FFFFFFFC", seen_p4, 1, 32'h0000_0000);

    // Randomized soak: random readiness, latencies, response gaps, redirects.
    setKnobs(1, 4, 70, 60, 80, 4);
    doReset();
    runCycles(3000);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetching until reset.
    setKnobs(2, 2, 100, 100, 100, 0);
    doReset();
    runCycles(3);
    redir_now = 1'b1;
    redir_target = 32'h0000_0102;
    runCycles(1);
    #1 chk("G_misaligned_set", fetch_misaligned, 1'b1);
    for (int i = 0; i < 6; i++) begin
      runCycles(1);
      #1;
      chk("G_no_request_in_halt", imem_req_valid, 1'b0);
      chk("G_misaligned_sticky", fetch_misaligned, 1'b1);
    end
    doReset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the RISC-V core: generates sequential PCs, issues word requests to the instruction memory, buffers returned instructions in a small prefetch queue, and hands them to the decode/control stage over a valid/ready handshake. Sits directly upstream of the register file, extend and control-unit logic, and replaces the free-running PC register plus PC+4 adder pair with a stallable, redirectable front end. Branch/jump redirects from execute flush the queue and discard stale in-flight responses.

## Interface
- DEPTH, 4, prefetch queue entries and maximum in-flight budget (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  request word address
- imem_rsp_valid  in  1  response valid (in order, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump taken; load new PC
- redirect_pc  in  32  redirect target
- instr_valid  out  1  decode-side instruction available
- instr_ready  in  1  decode consumes this cycle
- instr  out  32  instruction word at queue head
- instr_pc  out  32  PC of instr
- instr_pc_plus4  out  32  instr_pc + 4 (mod 2^32)

## Operation
- State machine: BOOT -> RUN (-> HALT only with macro). BOOT lasts exactly one cycle after rst deasserts; no request issued. RUN issues requests.
- Request issued (imem_req_valid=1) in RUN when: no redirect this cycle, and outstanding + count − pop < DEPTH (pop = instr_valid & instr_ready). imem_addr = fetch_pc. On accept (valid & ready) fetch_pc += 4, outstanding += 1. imem_req_valid/addr hold stable until accepted unless redirected.
- Response: outstanding −= 1. If drop_cnt > 0, discard and drop_cnt −= 1; else push {data, pc} into queue. Queue PCs come from a separate rsp_pc counter advancing by 4 per kept response, reloaded on redirect.
- Queue never overflows by construction (credit rule); a push into a full queue is an assertion failure.
- instr_valid = queue non-empty; instr/instr_pc/instr_pc_plus4 show head; pop on valid & ready.
- Redirect (highest priority): queue flushed, pending request withdrawn, fetch_pc and rsp_pc ← redirect_pc, drop_cnt ← outstanding − imem_rsp_valid (any response that cycle is discarded). Simultaneous pop ignored (queue cleared anyway).
- Arithmetic: all PC adds 32-bit wrap-around; 32'hFFFF_FFFC + 4 = 0.
- Reset (any time, incl. mid-flush): state BOOT, fetch_pc = rsp_pc = RESET_PC, queue empty, outstanding = drop_cnt = 0; outputs imem_req_valid=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_pc_plus4=RESET_PC+4.

## Timing
- Request accepted cycle T, response T+k (k≥1), instr_valid at T+k+1 (queue registered, no bypass).
- With k=1 and instr_ready held high, one instruction per cycle sustained from 3rd cycle after BOOT.
- Redirect cycle R: no request in R; first request to redirect_pc in R+1; first valid new instruction no earlier than R+3.
- Outstanding limited to DEPTH; counters sized clog2(DEPTH)+1.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: adds output fetch_misaligned (1 bit). Redirect with redirect_pc[1:0] ≠ 0 enters HALT: queue flushed, no further requests, fetch_misaligned=1 (registered) until reset; stale responses still drained via drop_cnt. Reset value 0.
- Undefined: no port, no HALT; redirect_pc[1:0] forced to 0 (word-aligned).

## Structure
- Shared package fetch_pkg: XLEN=32, NOP_INSTR=32'h0000_0013, fetch state enum (BOOT, RUN, HALT).
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of {pc, instr}, with push, pop, flush, count, empty/full; async reset clears pointers.

## Test plan
- Reset then 1-cycle memory, instr_ready=1 -> addresses 0,4,8,… issued from cycle 1 after BOOT; instr_pc 0,4,8 one per cycle, instr_pc_plus4 = 4,8,12.
- instr_ready=0 for 10 cycles -> exactly DEPTH=4 requests accepted, instr_valid=1 showing PC 0; release -> 0,4,8,12,16 in order, none lost/duplicated.
- 3-cycle memory latency, redirect_pc=32'h100 with 2 in flight -> both stale responses dropped; next instr_pc = 32'h100.
- imem_req_ready=0 for 5 cycles -> imem_addr/valid stable; redirect mid-wait to 32'h40 -> next accepted address 32'h40.
- Start at RESET_PC=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0; instr_pc_plus4 of FFFF_FFFC = 0.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=32'h102 -> fetch_misaligned=1 next cycle, imem_req_valid=0 thereafter, cleared only by rst.
